// File: rtl/slt_pkg.sv
// Shared definitions for the multi-cycle set-less-than unit.
//   state_t      : control FSM states (IDLE, RUN, DONE)
//   DEFAULT_*    : default operand width and slice width
//   N, IDX_W     : slice count and slice-index width for the defaults
//   idx_width()  : index width for an arbitrary slice count (never 0)
package slt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 4;
  localparam int N             = DEFAULT_WIDTH / DEFAULT_CHUNK;
  localparam int IDX_W         = $clog2(N);

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_set_less_than_chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
//   a, b : slice operands
//   lt   : a < b (unsigned)
//   eq   : a == b
module chunk_compare #(
  parameter int CHUNK = slt_pkg::DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_set_less_than.sv
// Multi-cycle set-less-than: compares a and b one CHUNK-bit slice per cycle,
// most significant slice first, under a start/done handshake.
//   clk, reset : clock, synchronous active-high reset
//   start      : capture request, honoured in IDLE or DONE
//   is_signed  : 1 = two's-complement compare, 0 = unsigned
//   a, b       : operands
//   busy       : high while comparing
//   done       : one-cycle pulse when lt/eq/result become valid
//   lt, eq     : a < b, a == b (held until next decision or reset)
//   result     : zero-extended lt
module seq_set_less_than
  import slt_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int CHUNK      = DEFAULT_CHUNK,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic [WIDTH-1:0] result
);

  localparam int              SLICES    = WIDTH / CHUNK;
  localparam int              IW        = idx_width(SLICES);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(SLICES - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             found_q, found_d;        // a differing slice already seen
  logic             first_lt_q, first_lt_d;  // lt of that first difference
  logic             lt_q, lt_d, eq_q, eq_d;

  // Slice select: shift the wanted slice to the top, then take the top CHUNK bits.
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CHUNK-1:0] a_slice, b_slice;
  logic             slice_lt, slice_eq;

  assign a_sh    = a_q << (int'(idx_q) * CHUNK);
  assign b_sh    = b_q << (int'(idx_q) * CHUNK);
  assign a_slice = a_sh[WIDTH-1 -: CHUNK];
  assign b_slice = b_sh[WIDTH-1 -: CHUNK];

  chunk_compare #(.CHUNK(CHUNK)) u_cmp (
    .a  (a_slice),
    .b  (b_slice),
    .lt (slice_lt),
    .eq (slice_eq)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    found_d    = found_q;
    first_lt_d = first_lt_q;
    lt_d       = lt_q;
    eq_d       = eq_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Flipping the sign bit of both operands maps two's-complement
          // order onto unsigned order, so RUN only ever does unsigned compares.
          a_d        = is_signed ? (a ^ SIGN_BIT) : a;
          b_d        = is_signed ? (b ^ SIGN_BIT) : b;
          idx_d      = '0;
          found_d    = 1'b0;
          first_lt_d = 1'b0;
          state_d    = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (EARLY_EXIT && !slice_eq) begin
          lt_d    = slice_lt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          // An earlier difference outranks whatever the last slice says.
          lt_d    = found_q ? first_lt_q : slice_lt;
          eq_d    = !found_q && slice_eq;
          state_d = DONE;
        end else begin
          if (!slice_eq && !found_q) begin
            found_d    = 1'b1;
            first_lt_d = slice_lt;
          end
          idx_d = idx_q + IW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      found_q    <= 1'b0;
      first_lt_q <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      found_q    <= found_d;
      first_lt_q <= first_lt_d;
      lt_q       <= lt_d;
      eq_q       <= eq_d;
    end
  end

  // NOTE: operand registers are deliberately not reset; they are always written at capture before being read.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign lt     = lt_q;
  assign eq     = eq_q;
  assign result = {{(WIDTH-1){1'b0}}, lt_q};

endmodule

// File: tb/tb_seq_set_less_than.sv
// Directed bench: one early-exit instance (dut1) and one full-scan instance
// (dut0) share operand inputs but have separate start strobes.
module tb_seq_set_less_than;

  logic        clk = 1'b0;
  logic        reset, start1, start0, is_signed;
  logic [31:0] a, b;

  logic        busy1, done1, lt1, eq1;
  logic [31:0] result1;
  logic        busy0, done0, lt0, eq0;
  logic [31:0] result0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_set_less_than #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy1), .done(done1), .lt(lt1), .eq(eq1),
    .result(result1)
  );

  seq_set_less_than #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy0), .done(done0), .lt(lt0), .eq(eq0),
    .result(result0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One operation on the selected instance; measures start-to-done latency.
  task automatic run_op(input bit ee0, input logic [31:0] av, input logic [31:0] bv,
                        input bit sg, input int exp_k, input bit exp_lt,
                        input bit exp_eq, input string tag);
    int cnt;
    bit seen;
    @(negedge clk);
    a = av; b = bv; is_signed = sg;
    if (ee0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    check({tag, ".busy"}, ee0 ? busy0 : busy1, 1);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      seen = ee0 ? done0 : done1;
    end
    check({tag, ".lat"}, cnt, exp_k);
    check({tag, ".lt"}, ee0 ? lt0 : lt1, exp_lt);
    check({tag, ".eq"}, ee0 ? eq0 : eq1, exp_eq);
    check({tag, ".res"}, ee0 ? result0 : result1, {31'b0, exp_lt});
    @(posedge clk); #1;
    check({tag, ".done_drop"}, ee0 ? done0 : done1, 0);
    check({tag, ".lt_hold"}, ee0 ? lt0 : lt1, exp_lt);
  endtask

  initial begin : main
    int  cnt;
    bit  seen;
    reset = 1'b1; start1 = 1'b0; start0 = 1'b0; is_signed = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy1, 0);
    check("rst.done", done1, 0);
    check("rst.lt", lt1, 0);
    check("rst.eq", eq1, 0);
    check("rst.res", result1, 0);
    check("rst.busy0", busy0, 0);
    check("rst.res0", result0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Early-exit instance
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1'b1, 1'b0, "ee1.sgn_neg1_vs_1");
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 1'b0, 1'b0, "ee1.uns_ff_vs_1");
    run_op(1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 8, 1'b0, 1'b1, "ee1.equal");
    run_op(1'b0, 32'h0000_0010, 32'h0000_0011, 1'b0, 8, 1'b1, 1'b0, "ee1.last_slice");
    run_op(1'b0, 32'h1000_0000, 32'h2000_0000, 1'b0, 1, 1'b1, 1'b0, "ee1.first_slice");
    run_op(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 1'b1, 1'b0, "ee1.sgn_min_vs_max");
    run_op(1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 1, 1'b0, 1'b0, "ee1.sgn_5_vs_m3");
    run_op(1'b0, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0, 1, 1'b1, 1'b0, "ee1.uns_5_vs_big");

    // Full-scan instance
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 8, 1'b1, 1'b0, "ee0.sgn_neg1_vs_1");
    run_op(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 8, 1'b0, 1'b1, "ee0.equal");
    run_op(1'b1, 32'h1000_0000, 32'h2000_0000, 1'b0, 8, 1'b1, 1'b0, "ee0.first_slice");
    run_op(1'b1, 32'h10F0_0000, 32'h2000_0000, 1'b0, 8, 1'b1, 1'b0, "ee0.first_diff_wins");
    run_op(1'b1, 32'h0000_0010, 32'h0000_0011, 1'b0, 8, 1'b1, 1'b0, "ee0.last_slice");

    // Start pulsed mid-RUN with operands that would flip the answer
    @(negedge clk);
    a = 32'h0000_0020; b = 32'h0000_0011; is_signed = 1'b0; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      seen = done0;
      if (cnt == 3) begin
        @(negedge clk);
        a = 32'h0000_0001; b = 32'h0000_0011; start0 = 1'b1;
      end else if (cnt == 4) begin
        @(negedge clk);
        start0 = 1'b0;
      end
    end
    check("ignore_start.lat", cnt, 8);
    check("ignore_start.lt", lt0, 0);
    check("ignore_start.eq", eq0, 0);

    // Leave result0 = 1, then reset three cycles into RUN
    run_op(1'b1, 32'h0000_0010, 32'h0000_0011, 1'b0, 8, 1'b1, 1'b0, "pre_abort");
    @(negedge clk);
    a = 32'h0000_0010; b = 32'h0000_0011; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", busy0, 0);
    check("abort.done", done0, 0);
    check("abort.res", result0, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0) seen = 1'b1;
    end
    check("abort.no_done", seen, 0);

    // Back-to-back: new start during the DONE cycle
    @(negedge clk);
    a = 32'h1000_0000; b = 32'h2000_0000; is_signed = 1'b0; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    check("b2b.first_done", done1, 1);
    check("b2b.first_lt", lt1, 1);
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1234_5678; start1 = 1'b1;
    @(posedge clk); #1;
    check("b2b.recapture_busy", busy1, 1);
    check("b2b.recapture_done", done1, 0);
    check("b2b.lt_held", lt1, 1);
    @(negedge clk);
    start1 = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      seen = done1;
      if (!seen) check("b2b.run_res_held", result1, 1);
    end
    check("b2b.second_lat", cnt, 8);
    check("b2b.second_eq", eq1, 1);
    check("b2b.second_lt", lt1, 0);
    check("b2b.second_res", result1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_set_less_than.md
# seq_set_less_than

Multi-cycle, parametrised set-less-than unit for the ALU datapath. It compares two WIDTH-bit operands in CHUNK-bit slices, MSB slice first, under a start/done handshake. It supports signed (slt) and unsigned (sltu) modes and can stop early once the result is known. It drives a zero-extended WIDTH-bit result whose bit 0 is the less-than flag, plus separate lt and eq flags for branch logic.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK
- CHUNK, 4, bits compared per cycle; N = WIDTH/CHUNK slices
- EARLY_EXIT, 1, 1 = finish on first differing slice; 0 = always take N cycles
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned compare
- a  input  WIDTH  left operand
- b  input  WIDTH  right operand
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse when the result becomes valid
- lt  output  1  a < b under the captured mode
- eq  output  1  a == b
- result  output  WIDTH  {WIDTH-1 zeros, lt}

## Operation
- States: IDLE, RUN, DONE.
- Reset forces IDLE and sets busy, done, lt, eq and result to 0.
- Capture: start in IDLE or DONE latches a, b and is_signed, clears slice index idx to 0, and moves to RUN.
  - If is_signed = 1, bit WIDTH-1 of both latched copies is inverted on capture. From that point every compare is unsigned.
- RUN: each cycle compares slice idx, bits [WIDTH-1-idx*CHUNK -: CHUNK], from a against the same slice from b.
  - Slices differ and EARLY_EXIT = 1: register lt = (a_slice < b_slice) and eq = 0, then go to DONE.
  - Slices differ and EARLY_EXIT = 0: record the first difference only; later slices are ignored.
  - idx = N-1 with no difference found: register eq = 1 and lt = 0, then go to DONE.
  - Otherwise increment idx.
- DONE: done = 1 for that cycle only. lt, eq and result hold until the next capture or reset. With no start, the state returns to IDLE the following cycle.
- A start in RUN is ignored; operands and mode are not re-sampled.
- Reset in any state, including mid-RUN, aborts the operation with no done pulse.

## Timing
- Start is sampled at edge E0; busy = 1 from E0.
- Slice i is evaluated in the cycle following E_i. The decision registers at E_k.
  - k = (index of first differing slice) + 1 when EARLY_EXIT = 1.
  - k = N when EARLY_EXIT = 0.
  - k = N when the operands are equal.
- Latency from start to done is k cycles, with 1 ≤ k ≤ N. done is high in the cycle after E_k, and busy falls at E_k.
- Back-to-back operation: a start during the DONE cycle captures at the next edge with no IDLE bubble. Throughput is 1 result per k+1 cycles.
- lt, eq and result change only at the decision edge or at reset. They keep their previous value throughout RUN.

## Structure
- Package slt_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH and CHUNK constants;
  - the localparam helper N = WIDTH/CHUNK;
  - an index width of clog2(N).
- Sub-module chunk_compare (parameter CHUNK) is purely combinational, with outputs lt and eq for one slice pair. It is instantiated once and fed by an idx-selected mux.
- The top level holds the FSM, the operand registers, the index counter and the output registers.

## Test plan
All scenarios use WIDTH = 32 and CHUNK = 4 unless stated.
- Signed: a = 0xFFFFFFFF, b = 0x00000001, is_signed = 1 → done 1 cycle after start; lt = 1, eq = 0, result = 0x00000001.
- Same operands, is_signed = 0 → done after 1 cycle; lt = 0, eq = 0, result = 0x00000000.
- a = b = 0x12345678 → done after 8 cycles with eq = 1 and lt = 0.
  - The same operands with EARLY_EXIT = 0 also give 8 cycles.
- Unsigned, difference in the last slice: a = 0x00000010, b = 0x00000011 → 8 cycles, lt = 1.
  - a = 0x10000000, b = 0x20000000 → 1 cycle (EARLY_EXIT = 1) or 8 cycles (EARLY_EXIT = 0), lt = 1 in both cases.
- Robustness:
  - Pulse start during RUN → ignored, and the original operands' result is reported.
  - Assert reset 3 cycles into RUN → next cycle busy = 0, done = 0, result = 0, and no done pulse follows.
- Back-to-back: start asserted in the DONE cycle with new operands → second capture at the next edge, and a second done pulse with the correct result.
